// File: rtl/capture_buffer.sv
// Trigger-qualified circular sample store for the internal logic analyzer.
// Captures a DEPTH-sample window around a trigger and replays it oldest-first over valid/ready.
module capture_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  trigger,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] pretrig_count,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  capturing,
    output logic                  armed,
    output logic                  done
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_READOUT
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] plen;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         post;
    logic [CW-1:0]         rd_cnt;
    logic [CW-1:0]         post_calc;
    logic                  wr_en;
    logic                  xfer;

    // Samples still to be written after the trigger so the window totals DEPTH.
    assign post_calc = CW'(DEPTH - 1) - CW'(plen);
    assign wr_en     = !reset && (state == S_FILL || state == S_ARMED || state == S_POST);
    assign xfer      = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (arm) state_next = (pretrig_count != '0) ? S_FILL : S_ARMED;
            S_FILL:    if (cnt + CW'(1) == CW'(plen)) state_next = S_ARMED;
            S_ARMED:   if (trigger) state_next = (post_calc == '0) ? S_READOUT : S_POST;
            S_POST:    if (cnt + CW'(1) == post) state_next = S_READOUT;
            S_READOUT: if (xfer && rd_last) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Sample memory is intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            plen      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            post      <= '0;
            rd_cnt    <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            capturing <= 1'b0;
            armed     <= 1'b0;
            done      <= 1'b0;
        end else begin
            capturing <= (state_next == S_FILL) || (state_next == S_ARMED) || (state_next == S_POST);
            armed     <= (state_next == S_ARMED);
            done      <= (state_next == S_READOUT);
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        plen   <= pretrig_count;
                        wr_ptr <= '0;
                        cnt    <= '0;
                    end
                end
                S_FILL: begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                    cnt    <= cnt + CW'(1);
                end
                S_ARMED: begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                    if (trigger) begin
                        post   <= post_calc;
                        cnt    <= '0;
                        rd_ptr <= wr_ptr - plen;
                        rd_cnt <= '0;
                    end
                end
                S_POST: begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                    cnt    <= cnt + CW'(1);
                end
                S_READOUT: begin
                    // One empty cycle between samples covers the synchronous memory read.
                    if (!rd_valid) begin
                        rd_valid <= 1'b1;
                        rd_data  <= mem[rd_ptr];
                        rd_last  <= (rd_cnt == CW'(DEPTH - 1));
                    end else if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                        rd_cnt   <= rd_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer at DEPTH=16: capture windows, trigger qualification,
// reset abort and readout back-pressure.
module tb_capture_buffer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data;
    logic          trigger;
    logic          arm;
    logic [AW-1:0] pretrig_count;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          capturing;
    logic          armed;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .data(data), .trigger(trigger), .arm(arm),
        .pretrig_count(pretrig_count), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_last(rd_last), .capturing(capturing), .armed(armed),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " rd_valid"}, 32'(rd_valid), 0);
        check({tag, " rd_data"}, 32'(rd_data), 0);
        check({tag, " rd_last"}, 32'(rd_last), 0);
        check({tag, " capturing"}, 32'(capturing), 0);
        check({tag, " armed"}, 32'(armed), 0);
        check({tag, " done"}, 32'(done), 0);
    endtask

    // Arm (with a stray trigger that must be ignored), then stream data 0,1,2,... until done.
    task automatic capture(input int pre, input int t1, input int t2, input int end_d);
        int d;
        pretrig_count = AW'(pre);
        arm = 1'b1;
        trigger = 1'b1;
        step();
        arm = 1'b0;
        check("arm capturing", 32'(capturing), 1);
        check("arm armed", 32'(armed), (pre == 0) ? 1 : 0);
        d = 0;
        while (!done && d < 200) begin
            data = DW'(d);
            trigger = (d == t1) || (d == t2);
            step();
            d++;
        end
        trigger = 1'b0;
        check("done reached", 32'(done), 1);
        check("done cycle", 32'(d), 32'(end_d));
        check("done capturing", 32'(capturing), 0);
    endtask

    // Drain the window, checking order, rd_last, the one-cycle gap and optional stall hold.
    task automatic readout(input int first, input bit stall);
        int idx = 0;
        int held = 0;
        int guard = 0;
        rd_ready = 1'b0;
        while (idx < 16 && guard < 400) begin
            if (rd_valid) begin
                if (stall && idx == 0 && held < 5) begin
                    check("stall data", 32'(rd_data), 32'(first));
                    rd_ready = 1'b0;
                    held++;
                    step();
                    check("stall valid", 32'(rd_valid), 1);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(first + idx));
                    check("rd_last", 32'(rd_last), (idx == 15) ? 1 : 0);
                    rd_ready = 1'b1;
                    step();
                    rd_ready = 1'b0;
                    idx++;
                    check("gap", 32'(rd_valid), 0);
                end
            end else begin
                step();
            end
            guard++;
        end
        check("readout count", 32'(idx), 16);
        check("end done", 32'(done), 0);
        step();
        check("end valid", 32'(rd_valid), 0);
    endtask

    initial begin
        reset = 1'b1;
        data = '0;
        trigger = 1'b0;
        arm = 1'b0;
        pretrig_count = '0;
        rd_ready = 1'b0;
        step();
        step();
        check_idle("reset");
        reset = 1'b0;
        step();
        check_idle("idle");

        capture(4, 20, 20, 32);
        readout(16, 1'b0);

        capture(0, 5, 5, 21);
        readout(5, 1'b0);

        capture(15, 30, 30, 31);
        readout(15, 1'b0);

        capture(8, 3, 40, 48);
        readout(32, 1'b0);

        // Abort during POST, then repeat the first case with a stalled consumer.
        pretrig_count = AW'(4);
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int d = 0; d < 25; d++) begin
            data = DW'(d);
            trigger = (d == 20);
            step();
        end
        trigger = 1'b0;
        check("post capturing", 32'(capturing), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("abort");
        step();
        check_idle("abort hold");

        capture(4, 20, 20, 32);
        readout(16, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
